// File: rtl/lieat_axi_pkg.sv
// Shared AXI definitions: id/len widths, burst and response encodings, and the AR lock state.
package lieat_axi_pkg;
    localparam int unsigned AXI_ID_W  = 4;
    localparam int unsigned AXI_LEN_W = 8;
    localparam int unsigned AXI_CNT_W = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;
endpackage

// File: rtl/lieat_general_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset to a parameterised value.
module lieat_general_dfflr #(
    parameter int unsigned     W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/lieat_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping at N-1.
module lieat_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_c
);
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant_c[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lieat_axi_rd_arbiter.sv
// N-to-1 AXI4 read arbiter with grant lock, outstanding-AR limit and id-based R routing.
// Define LIEAT_AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
module lieat_axi_rd_arbiter
    import lieat_axi_pkg::*;
#(
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_OUTS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD-1:0]          rq_arvalid,
    input  logic [NUM_RD*ADDR_W-1:0]   rq_araddr,
    input  logic [NUM_RD*3-1:0]        rq_arsize,
    output logic [NUM_RD-1:0]          rq_arready,
    output logic [NUM_RD-1:0]          rq_rvalid,
    input  logic [NUM_RD-1:0]          rq_rready,
    output logic [DATA_W-1:0]          rq_rdata,
    output logic                       io_master_arvalid,
    input  logic                       io_master_arready,
    output logic [ADDR_W-1:0]          io_master_araddr,
    output logic [AXI_ID_W-1:0]        io_master_arid,
    output logic [AXI_LEN_W-1:0]       io_master_arlen,
    output logic [2:0]                 io_master_arsize,
    output logic [1:0]                 io_master_arburst,
    input  logic                       io_master_rvalid,
    output logic                       io_master_rready,
    input  logic [DATA_W-1:0]          io_master_rdata,
    input  logic [1:0]                 io_master_rresp,
    input  logic                       io_master_rlast,
    input  logic [AXI_ID_W-1:0]        io_master_rid,
    output logic                       rd_err
);
    localparam int unsigned IDX_W = $clog2(NUM_RD);

    arb_state_e             state_q, state_d;
    logic                   state_bit_q, state_bit_d;
    logic [IDX_W-1:0]       win_q, win_d, arb_ptr, arb_idx, cur_idx, ptr_d;
    logic [NUM_RD-1:0]      grant;
    logic [AXI_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   err_d, ar_hs, r_hs, rlast_hs, rid_ok;

    lieat_rr_arbiter #(.N(NUM_RD), .IDX_W(IDX_W)) u_arb (
        .req     (rq_arvalid),
        .ptr     (arb_ptr),
        .grant_c (grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (grant[i]) arb_idx = IDX_W'(i);
        end
    end

    // Lock state register
    assign state_bit_d = state_d;
    assign state_q     = arb_state_e'(state_bit_q);
    lieat_general_dfflr #(.W(1))     u_state (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_bit_d), .q(state_bit_q));
    lieat_general_dfflr #(.W(IDX_W)) u_win   (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(win_d), .q(win_q));

    // Lock the winner when arvalid is presented without an immediate handshake
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            ARB_IDLE: begin
                if (io_master_arvalid && !io_master_arready) begin
                    state_d = ARB_LOCKED;
                    win_d   = arb_idx;
                end
            end
            ARB_LOCKED: begin
                if (ar_hs) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // AR channel outputs; reset gates arvalid immediately
    always_comb begin
        cur_idx           = (state_q == ARB_LOCKED) ? win_q : arb_idx;
        io_master_arvalid = rst_n & ((|rq_arvalid) | (state_q == ARB_LOCKED))
                            & (cnt_q < AXI_CNT_W'(MAX_OUTS));
        io_master_araddr  = '0;
        io_master_arsize  = '0;
        rq_arready        = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (cur_idx == IDX_W'(i)) begin
                io_master_araddr = rq_araddr[i*ADDR_W +: ADDR_W];
                io_master_arsize = rq_arsize[i*3 +: 3];
                rq_arready[i]    = io_master_arready & io_master_arvalid;
            end
        end
        io_master_arid    = AXI_ID_W'(cur_idx);
        io_master_arlen   = '0;
        io_master_arburst = AXI_BURST_INCR;
    end

    assign ar_hs = io_master_arvalid & io_master_arready;

`ifdef LIEAT_AXI_RD_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
    assign ptr_d   = '0;
`else
    assign ptr_d = (cur_idx == IDX_W'(NUM_RD - 1)) ? '0 : cur_idx + IDX_W'(1);
    lieat_general_dfflr #(.W(IDX_W)) u_ptr (.clk(clk), .rst_n(rst_n), .en(ar_hs), .d(ptr_d), .q(arb_ptr));
`endif

    // R routing by rid; unroutable ids are accepted and dropped
    always_comb begin
        rid_ok           = 1'b0;
        io_master_rready = 1'b1;
        rq_rvalid        = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (io_master_rid == AXI_ID_W'(i)) begin
                rid_ok           = 1'b1;
                io_master_rready = rq_rready[i];
                rq_rvalid[i]     = io_master_rvalid;
            end
        end
    end

    assign rq_rdata = io_master_rdata;
    assign r_hs     = io_master_rvalid & io_master_rready;
    assign rlast_hs = r_hs & io_master_rlast;

    // Outstanding count: simultaneous AR and last-beat handshakes cancel; saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (ar_hs && !rlast_hs) begin
            cnt_d = cnt_q + AXI_CNT_W'(1);
        end else if (!ar_hs && rlast_hs && (cnt_q != '0)) begin
            cnt_d = cnt_q - AXI_CNT_W'(1);
        end
        err_d = r_hs & ((io_master_rresp != AXI_RESP_OKAY) | !rid_ok | (cnt_q == '0));
    end

    lieat_general_dfflr #(.W(AXI_CNT_W)) u_cnt (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(cnt_d), .q(cnt_q));
    lieat_general_dfflr #(.W(1))         u_err (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(err_d), .q(rd_err));
endmodule

// File: tb/tb_lieat_axi_rd_arbiter.sv
// Bench for lieat_axi_rd_arbiter: directed corner sequences, an R-routing vector table and a randomized model run.
module tb_lieat_axi_rd_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MO = 2;

    logic            clk, rst_n;
    logic [N-1:0]    rq_arvalid, rq_arready, rq_rvalid, rq_rready;
    logic [N*AW-1:0] rq_araddr;
    logic [N*3-1:0]  rq_arsize;
    logic [DW-1:0]   rq_rdata;
    logic            io_master_arvalid, io_master_arready;
    logic [AW-1:0]   io_master_araddr;
    logic [3:0]      io_master_arid;
    logic [7:0]      io_master_arlen;
    logic [2:0]      io_master_arsize;
    logic [1:0]      io_master_arburst;
    logic            io_master_rvalid, io_master_rready, io_master_rlast;
    logic [DW-1:0]   io_master_rdata;
    logic [1:0]      io_master_rresp;
    logic [3:0]      io_master_rid;
    logic            rd_err;

    int checks = 0;
    int errors = 0;

    lieat_axi_rd_arbiter #(.NUM_RD(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTS(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_arvalid(rq_arvalid), .rq_araddr(rq_araddr), .rq_arsize(rq_arsize),
        .rq_arready(rq_arready), .rq_rvalid(rq_rvalid), .rq_rready(rq_rready), .rq_rdata(rq_rdata),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
        .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
        .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rvalid;
        logic [3:0] rid;
        logic [1:0] rresp;
        logic [1:0] rready_in;
        logic [1:0] exp_rvalid;
        logic       exp_rready;
        logic       exp_err;
    } rvec_t;

    rvec_t tbl[9];
    int    exp_id[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rq_arvalid = '0; rq_araddr = '0; rq_arsize = '0; rq_rready = '0;
        io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
        io_master_rdata = '0; io_master_rresp = 2'b00; io_master_rid = '0;
    endtask

    // Reference model state (abstract: pointer, lock, count, pending error)
    int m_ptr, m_win, m_cnt;
    bit m_locked, m_err;

    task automatic model_cycle();
        int  w;
        bit  any, found, e_av, arhs, rhs, routable, e_rr;
        any = (rq_arvalid != '0);
        w = 0;
        if (m_locked) begin
            w = m_win;
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && rq_arvalid[(m_ptr + k) % N]) begin
                    w = (m_ptr + k) % N;
                    found = 1;
                end
            end
        end
        e_av = (any || m_locked) && (m_cnt < MO);
        chk("rnd_arvalid", 64'(io_master_arvalid), 64'(e_av));
        if (e_av) begin
            chk("rnd_arid", 64'(io_master_arid), 64'(w));
            chk("rnd_araddr", 64'(io_master_araddr), 64'(rq_araddr[w*AW +: AW]));
            chk("rnd_arsize", 64'(io_master_arsize), 64'(rq_arsize[w*3 +: 3]));
        end
        chk("rnd_rq_arready", 64'(rq_arready), (e_av && io_master_arready) ? 64'(1 << w) : 64'(0));
        routable = (int'(io_master_rid) < N);
        e_rr = routable ? rq_rready[io_master_rid] : 1'b1;
        chk("rnd_rq_rvalid", 64'(rq_rvalid), (io_master_rvalid && routable) ? 64'(1 << io_master_rid) : 64'(0));
        chk("rnd_rready", 64'(io_master_rready), 64'(e_rr));
        chk("rnd_rd_err", 64'(rd_err), 64'(m_err));
        arhs = e_av && io_master_arready;
        rhs  = io_master_rvalid && e_rr;
        m_err = rhs && (io_master_rresp != 2'b00 || !routable || m_cnt == 0);
        if (arhs && !(rhs && io_master_rlast)) m_cnt++;
        else if (!arhs && rhs && io_master_rlast && m_cnt > 0) m_cnt--;
        if (arhs) begin
            m_locked = 0;
`ifndef LIEAT_AXI_RD_ARB_FIXED_PRIO_EN
            m_ptr = (w + 1) % N;
`endif
        end else if (e_av) begin
            m_locked = 1;
            m_win = w;
        end
    endtask

    initial begin
        logic prev_err;
        tbl[0] = '{1'b1, 4'd0,  2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 4'd1,  2'b00, 2'b01, 2'b10, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 4'd1,  2'b00, 2'b10, 2'b10, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'd5,  2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 4'd0,  2'b00, 2'b11, 2'b00, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 4'd0,  2'b10, 2'b01, 2'b01, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 4'd0,  2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 4'd15, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 4'd1,  2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
`ifdef LIEAT_AXI_RD_ARB_FIXED_PRIO_EN
        exp_id[0] = 0; exp_id[1] = 0; exp_id[2] = 0; exp_id[3] = 0; exp_id[4] = 0; exp_id[5] = 0;
`else
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 0; exp_id[3] = 1; exp_id[4] = 0; exp_id[5] = 1;
`endif
        // Reset state, with requests already pending
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        rq_arvalid = 2'b11; io_master_arready = 1'b1;
        #1;
        chk("rst_arvalid", 64'(io_master_arvalid), 64'(0));
        chk("rst_rq_arready", 64'(rq_arready), 64'(0));
        chk("rst_rd_err", 64'(rd_err), 64'(0));
        nxt();
        rst_n = 1'b1;

        // Arbitration sequence with cancelling AR/R-last handshakes, then the outstanding limit
        rq_araddr = {32'hBBBB_0001, 32'hAAAA_0000};
        for (int c = 0; c < 5; c++) begin
            io_master_rvalid = (c >= 1 && c <= 3); io_master_rlast = 1'b1;
            io_master_rid = 4'd0; rq_rready = 2'b11;
            #1;
            chk("rr_arvalid", 64'(io_master_arvalid), 64'(1));
            chk("rr_arid", 64'(io_master_arid), 64'(exp_id[c]));
            chk("rr_rq_arready", 64'(rq_arready), 64'(1 << exp_id[c]));
            chk("rr_rd_err", 64'(rd_err), 64'(0));
            nxt();
        end
        io_master_rvalid = 1'b1; io_master_rid = 4'd1; rq_rready = 2'b10;
        #1;
        chk("full_arvalid", 64'(io_master_arvalid), 64'(0));
        chk("full_rq_arready", 64'(rq_arready), 64'(0));
        chk("full_rq_rvalid", 64'(rq_rvalid), 64'(2'b10));
        nxt();
        io_master_rvalid = 1'b0;
        #1;
        chk("reissue_arvalid", 64'(io_master_arvalid), 64'(1));
        chk("reissue_arid", 64'(io_master_arid), 64'(exp_id[5]));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_arvalid", 64'(io_master_arvalid), 64'(0));
        chk("async_rst_rq_arready", 64'(rq_arready), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_inputs();

        // Underflow after reset: count must have been cleared
        nxt();
        io_master_rvalid = 1'b1; io_master_rlast = 1'b1; io_master_rid = 4'd0; rq_rready = 2'b01;
        #1 chk("uf_rq_rvalid", 64'(rq_rvalid), 64'(2'b01));
        nxt();
        io_master_rvalid = 1'b0;
        #1 chk("uf_rd_err", 64'(rd_err), 64'(1));
        nxt();
        #1 chk("uf_rd_err_pulse", 64'(rd_err), 64'(0));

        // Locked grant held across a stalled handshake
        nxt();
        idle_inputs();
        rq_arvalid = 2'b10; rq_araddr = {32'h8000_0000, 32'h0}; rq_arsize = {3'd3, 3'd0};
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                rq_arvalid = 2'b11;
                rq_araddr[31:0] = 32'h0000_1234;
            end
            #1;
            chk("lock_arvalid", 64'(io_master_arvalid), 64'(1));
            chk("lock_araddr", 64'(io_master_araddr), 64'(32'h8000_0000));
            chk("lock_arid", 64'(io_master_arid), 64'(1));
            chk("lock_rq_arready", 64'(rq_arready), 64'(0));
            nxt();
        end
        io_master_arready = 1'b1;
        #1;
        chk("lock_hs_rq_arready", 64'(rq_arready), 64'(2'b10));
        chk("lock_hs_arsize", 64'(io_master_arsize), 64'(3));
        chk("arlen", 64'(io_master_arlen), 64'(0));
        chk("arburst", 64'(io_master_arburst), 64'(2'b01));
        nxt();
        rq_arvalid = 2'b01;
        #1;
        chk("next_arid", 64'(io_master_arid), 64'(0));
        chk("next_araddr", 64'(io_master_araddr), 64'(32'h0000_1234));
        chk("next_rq_arready", 64'(rq_arready), 64'(2'b01));

        // R routing vector table (two transactions outstanding, no last beats)
        prev_err = 1'b0;
        for (int i = 0; i < 9; i++) begin
            nxt();
            rq_arvalid = '0; io_master_arready = 1'b0; io_master_rlast = 1'b0;
            io_master_rvalid = tbl[i].rvalid; io_master_rid = tbl[i].rid;
            io_master_rresp = tbl[i].rresp; rq_rready = tbl[i].rready_in;
            io_master_rdata = {$urandom, $urandom};
            #1;
            chk("tbl_rd_err", 64'(rd_err), 64'(prev_err));
            chk("tbl_rq_rvalid", 64'(rq_rvalid), 64'(tbl[i].exp_rvalid));
            chk("tbl_rready", 64'(io_master_rready), 64'(tbl[i].exp_rready));
            chk("tbl_rdata", rq_rdata, io_master_rdata);
            prev_err = tbl[i].exp_err;
        end
        nxt();
        #1 chk("tbl_rd_err_last", 64'(rd_err), 64'(prev_err));

        // Randomized run against the reference model
        rst_n = 1'b0;
        idle_inputs();
        nxt();
        rst_n = 1'b1;
        m_ptr = 0; m_win = 0; m_cnt = 0; m_locked = 0; m_err = 0;
        for (int c = 0; c < 600; c++) begin
            nxt();
            rq_arvalid = N'($urandom_range(0, 3));
            rq_araddr = {$urandom, $urandom};
            rq_arsize = 6'($urandom);
            io_master_arready = ($urandom_range(0, 1) == 1);
            io_master_rvalid = ($urandom_range(0, 1) == 1);
            io_master_rid = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
            io_master_rresp = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom);
            io_master_rlast = ($urandom_range(0, 1) == 1);
            rq_rready = N'($urandom_range(0, 3));
            io_master_rdata = {$urandom, $urandom};
            #1;
            model_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1);
    end
endmodule

// File: doc/lieat_axi_rd_arbiter.md
LIEAT_AXI_RD_ARBITER -- requirements
Module: lieat_axi_rd_arbiter

Interface
REQ-001 Parameter NUM_RD, default 2: number of read requester ports, range 2..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 64: read data width.
REQ-004 Parameter MAX_OUTS, default 4: maximum accepted-but-unreturned AR transactions, range 1..15.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rq_arvalid  input  NUM_RD  per-port read request valid.
REQ-008 rq_araddr  input  NUM_RD*ADDR_W  per-port address; port i occupies slice i.
REQ-009 rq_arsize  input  NUM_RD*3  per-port transfer size.
REQ-010 rq_arready  output  NUM_RD  per-port AR accept.
REQ-011 rq_rvalid  output  NUM_RD  per-port read data valid.
REQ-012 rq_rready  input  NUM_RD  per-port read data ready.
REQ-013 rq_rdata  output  DATA_W  shared read data, qualified by rq_rvalid.
REQ-014 io_master_ar{valid,ready,addr,id,len,size,burst}: standard AXI4 AR channel; id 4 bits, len 8 bits.
REQ-015 io_master_r{valid,ready,data,resp,last,id}: standard AXI4 R channel.
REQ-016 rd_err  output  1  one-cycle pulse on an error response or unroutable rid.

Function
REQ-017 The arbiter SHALL grant round-robin among asserted rq_arvalid, searching upward from rr_ptr and wrapping from NUM_RD-1 to 0.
REQ-018 Once io_master_arvalid rises, the grant SHALL lock, and araddr, arsize, and arid SHALL stay stable until the arvalid&arready handshake.
REQ-019 After the handshake, rr_ptr SHALL be set to winner+1, modulo NUM_RD.
REQ-020 io_master_arid SHALL be the winner index zero-extended to 4 bits; arlen=0; arburst=2'b01.
REQ-021 rq_arready[i] SHALL equal io_master_arready & io_master_arvalid & (locked winner==i).
REQ-022 io_master_arvalid SHALL be (any rq_arvalid | locked) & (outs_cnt < MAX_OUTS).
REQ-023 outs_cnt SHALL increment on an AR handshake and decrement on an R handshake with rlast; if both occur in one cycle it SHALL hold.
REQ-024 When outs_cnt==MAX_OUTS, arvalid SHALL be low the same cycle; a locked grant is retained, and arvalid reasserts when the count drops.
REQ-025 R routing SHALL be combinational: rq_rvalid[rid]=io_master_rvalid; io_master_rready=rq_rready[rid]; zero latency.
REQ-026 An rid >= NUM_RD SHALL force rready=1 (data dropped) and pulse rd_err.
REQ-027 An R handshake with rresp != 2'b00 SHALL pulse rd_err the next cycle; data is still delivered.
REQ-028 outs_cnt underflow, i.e. an R handshake at count 0, SHALL saturate at 0 and pulse rd_err.

Reset
REQ-029 During reset, io_master_arvalid=0, rq_arready=0, rd_err=0, rr_ptr=0, outs_cnt=0, and the lock is cleared.
REQ-030 Reset mid-transaction SHALL discard all outstanding tracking; no retry.

Configuration
REQ-031 With LIEAT_AXI_RD_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and rr_ptr SHALL be removed.
REQ-032 Without the macro, round-robin per REQ-017 SHALL apply; the lock rule applies in both modes.

Structure
REQ-033 AXI burst/resp encodings and the 4-bit id width SHALL live in the shared lieat_axi package of defines.
REQ-034 One sub-module, lieat_rr_arbiter (request vector and pointer in, one-hot grant out), is natural; state regs use lieat_general_dfflr.

Verification
REQ-035 NUM_RD=2: both arvalid held, arready=1 -> arid sequence 0,1,0,1; each rq_arready pulses on alternate cycles.
REQ-036 Port 1 asserts arvalid with araddr=0x8000_0000, arready held low 5 cycles -> araddr and arid=1 stable all 5 cycles; a request from port 0 arriving mid-wait does not switch the grant.
REQ-037 MAX_OUTS=2: three back-to-back ARs with no R -> third arvalid low until the first rlast handshake, then issued the next cycle.
REQ-038 AR and R-last handshakes in the same cycle at outs_cnt=1 -> outs_cnt stays 1.
REQ-039 rid=5 with NUM_RD=2 -> rready=1, no rq_rvalid, and one rd_err pulse; rresp=2'b10 to port 0 -> data delivered and rd_err pulses.
REQ-040 With the FIXED_PRIO macro defined: ports 0 and 1 requesting continuously -> port 0 always granted; reset asserted mid-burst -> arvalid drops asynchronously and outs_cnt=0.
